// File: rtl/symbol_source_pkg.sv
// Shared encodings for the oversampled PRBS symbol source.
// Pattern modes, FSM states, LFSR tap positions and the feedback/seed helpers.
package symbol_source_pkg;

  typedef enum logic [1:0] {
    MODE_PRBS7  = 2'b00,
    MODE_PRBS9  = 2'b01,
    MODE_PRBS15 = 2'b10,
    MODE_ALT    = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STALL = 2'b10
  } state_e;

  localparam int LFSR_W  = 15;
  localparam int TAP7_A  = 6;
  localparam int TAP7_B  = 5;
  localparam int TAP9_A  = 8;
  localparam int TAP9_B  = 4;
  localparam int TAP15_A = 14;
  localparam int TAP15_B = 13;

  // Alternating mode reuses the shift register: feedback is the inverse of the last output.
  function automatic logic lfsr_fb(input mode_e mode, input logic [LFSR_W-1:0] s);
    logic fb;
    case (mode)
      MODE_PRBS7:  fb = s[TAP7_A] ^ s[TAP7_B];
      MODE_PRBS9:  fb = s[TAP9_A] ^ s[TAP9_B];
      MODE_PRBS15: fb = s[TAP15_A] ^ s[TAP15_B];
      MODE_ALT:    fb = ~s[0];
      default:     fb = 1'b0;
    endcase
    return fb;
  endfunction

  // A zero seed in alternating mode makes the first output bit a one.
  function automatic logic [LFSR_W-1:0] lfsr_seed(input mode_e mode, input int ch);
    logic [LFSR_W-1:0] seed;
    if (mode == MODE_ALT) begin
      seed = {LFSR_W{1'b0}};
    end else begin
      seed = (ch > 0) ? ~(15'd1 << ch) : {LFSR_W{1'b1}};
    end
    return seed;
  endfunction

endpackage

// File: rtl/symbol_source_if.sv
// Symbol stream handshake between the source and its consumer.
interface symbol_source_if #(
  parameter int N_CH = 2
) ();
  logic            o_valid;
  logic            i_ready;
  logic [N_CH-1:0] o_data;

  modport master (output o_valid, output o_data, input i_ready);
  modport slave  (input o_valid, input o_data, output i_ready);
endinterface

// File: rtl/symbol_source_lfsr.sv
// One 15-bit pattern register with mode-selected taps, seed load and step enable.
// o_fb is the bit the register would shift in on the next step.
module prbs_lfsr_multi
  import symbol_source_pkg::*;
#(
  parameter int CH_IDX = 0
) (
  input  logic  clock,
  input  logic  i_reset,
  input  logic  i_load,
  input  logic  i_step,
  input  mode_e i_mode,
  output logic  o_fb
);

  logic [LFSR_W-1:0] r_lfsr;
  logic              w_fb;

  assign w_fb = lfsr_fb(i_mode, r_lfsr);
  assign o_fb = w_fb;

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      r_lfsr <= lfsr_seed(MODE_PRBS7, CH_IDX);
    end else if (i_load) begin
      r_lfsr <= lfsr_seed(i_mode, CH_IDX);
    end else if (i_step) begin
      r_lfsr <= {r_lfsr[LFSR_W-2:0], w_fb};
    end else begin
      r_lfsr <= r_lfsr;
    end
  end

endmodule

// File: rtl/symbol_source.sv
// Oversampled multi-channel PRBS symbol source with valid/ready output,
// single-bit error injection on channel 0 and an accepted-symbol counter.
module symbol_source
  import symbol_source_pkg::*;
#(
  parameter int OS_LOG2 = 2,
  parameter int N_CH    = 2,
  parameter int NB_SCNT = 16
) (
  input  logic                 clock,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic [1:0]           i_mode,
  input  logic                 i_inject,
  symbol_source_if.master      sym,
  output logic [1:0]           o_state,
  output logic [NB_SCNT-1:0]   o_sym_cnt
);

  localparam int NB_PH = (OS_LOG2 == 0) ? 1 : OS_LOG2;
  localparam logic [NB_PH-1:0] PH_MAX = NB_PH'((32'd1 << OS_LOG2) - 32'd1);

  state_e             r_state;
  mode_e              r_mode;
  logic [NB_PH-1:0]   r_phase;
  logic               r_valid;
  logic [N_CH-1:0]    r_data;
  logic               r_inj;
  logic [NB_SCNT-1:0] r_cnt;

  logic [N_CH-1:0]    w_fb;
  logic [N_CH-1:0]    w_inj_mask;
  mode_e              w_mode_sel;
  logic               w_xfer;
  logic               w_pending;
  logic               w_produce;
  logic               w_load;
  logic               w_inj_any;

  assign w_xfer     = r_valid & sym.i_ready;
  assign w_pending  = r_valid & ~sym.i_ready;
  assign w_inj_any  = r_inj | i_inject;
  assign w_inj_mask = N_CH'(w_inj_any);
  assign w_produce  = i_enable & (r_state == ST_RUN) & (r_phase == PH_MAX) & ~w_pending;
  assign w_load     = i_enable & (r_state == ST_IDLE);
  // The live mode input only matters on the edge that leaves IDLE.
  assign w_mode_sel = (r_state == ST_IDLE) ? mode_e'(i_mode) : r_mode;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    prbs_lfsr_multi #(
      .CH_IDX (k)
    ) u_lfsr (
      .clock   (clock),
      .i_reset (i_reset),
      .i_load  (w_load),
      .i_step  (w_produce),
      .i_mode  (w_mode_sel),
      .o_fb    (w_fb[k])
    );
  end

  // Control FSM, phase counter, output symbol register and transfer counter.
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_PRBS7;
      r_phase <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_inj   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_xfer) begin
        r_cnt <= r_cnt + NB_SCNT'(1);
      end else begin
        r_cnt <= r_cnt;
      end
      if (!i_enable) begin
        r_state <= ST_IDLE;
        r_phase <= '0;
        r_valid <= 1'b0;
        r_inj   <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_RUN;
            r_mode  <= mode_e'(i_mode);
            r_phase <= '0;
            r_inj   <= w_inj_any;
          end
          ST_RUN: begin
            r_phase <= (r_phase == PH_MAX) ? '0 : r_phase + NB_PH'(1);
            if (w_produce) begin
              r_valid <= 1'b1;
              r_data  <= w_fb ^ w_inj_mask;
              r_inj   <= 1'b0;
            end else begin
              r_inj <= w_inj_any;
              if (w_xfer) begin
                r_valid <= 1'b0;
              end else if (w_pending) begin
                r_state <= ST_STALL;
              end else begin
                r_valid <= r_valid;
              end
            end
          end
          ST_STALL: begin
            r_inj <= w_inj_any;
            if (sym.i_ready) begin
              r_valid <= 1'b0;
              r_state <= ST_RUN;
            end else begin
              r_state <= ST_STALL;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign sym.o_valid = r_valid;
  assign sym.o_data  = r_data;
  assign o_state     = r_state;
  assign o_sym_cnt   = r_cnt;

endmodule

// File: tb/tb_symbol_source.sv
// Scoreboard bench for symbol_source: expected symbols come from the PRBS
// recurrences x[n] = x[n-a] ^ x[n-b] seeded from the per-channel seed words.
module tb_symbol_source;

  localparam int N_CH    = 3;
  localparam int OS_LOG2 = 2;
  localparam int NB_SCNT = 4;
  localparam int NSYM    = 300;

  logic               clock = 1'b0;
  logic               i_reset;
  logic               i_enable;
  logic [1:0]         i_mode;
  logic               i_inject;
  logic [1:0]         o_state;
  logic [NB_SCNT-1:0] o_sym_cnt;

  symbol_source_if #(.N_CH(N_CH)) sym ();

  symbol_source #(
    .OS_LOG2 (OS_LOG2),
    .N_CH    (N_CH),
    .NB_SCNT (NB_SCNT)
  ) dut (
    .clock     (clock),
    .i_reset   (i_reset),
    .i_enable  (i_enable),
    .i_mode    (i_mode),
    .i_inject  (i_inject),
    .sym       (sym),
    .o_state   (o_state),
    .o_sym_cnt (o_sym_cnt)
  );

  always #5 clock = ~clock;

  int                 n_checks = 0;
  int                 n_errors = 0;
  logic [N_CH-1:0]    exp_q[$];
  logic [NB_SCNT-1:0] mdl_cnt = '0;
  int                 sess_pops = 0;

  function automatic void chk(input bit ok, input string name, input longint act, input longint req);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endfunction

  // Expected symbols for a whole session, from the recurrence of the selected pattern.
  function automatic void push_session(input int mode);
    int ta;
    int tb2;
    bit h [NSYM+15];
    logic [N_CH-1:0] v [NSYM];
    ta  = (mode == 0) ? 7 : (mode == 1) ? 9 : 15;
    tb2 = (mode == 0) ? 6 : (mode == 1) ? 5 : 14;
    for (int k = 0; k < N_CH; k++) begin
      for (int i = 0; i < 15; i++) h[14-i] = (k > 0 && i == k) ? 1'b0 : 1'b1;
      for (int n = 0; n < NSYM; n++) begin
        if (mode == 3) h[n+15] = (n % 2 == 0);
        else           h[n+15] = h[n+15-ta] ^ h[n+15-tb2];
        v[n][k] = h[n+15];
      end
    end
    for (int n = 0; n < NSYM; n++) exp_q.push_back(v[n]);
  endfunction

  // Monitor: count check every cycle, pop and compare on each pending transfer.
  always @(negedge clock) begin
    logic [N_CH-1:0] e;
    if (!i_reset) begin
      chk(o_sym_cnt == mdl_cnt, "sym_cnt", o_sym_cnt, mdl_cnt);
      if (sym.o_valid && sym.i_ready) begin
        chk(exp_q.size() != 0, "exp_queue_empty", exp_q.size(), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk(sym.o_data == e, "symbol_data", sym.o_data, e);
        end
        mdl_cnt   = mdl_cnt + 1'b1;
        sess_pops = sess_pops + 1;
      end
    end
  end

  task automatic step(input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_xfer(output int cyc);
    int c0;
    c0  = sess_pops;
    cyc = 0;
    while (sess_pops == c0 && cyc < 64) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    chk(sess_pops != c0, "xfer_timeout", cyc, 64);
  endtask

  task automatic start_session(input logic [1:0] m);
    i_mode    = m;
    exp_q.delete();
    sess_pops = 0;
    push_session(int'(m));
    i_enable  = 1'b1;
  endtask

  task automatic stop_session();
    i_enable    = 1'b0;
    sym.i_ready = 1'b0;
    step(3);
    chk(o_state == 2'b00, "idle_state", o_state, 0);
    chk(sym.o_valid == 1'b0, "idle_valid", sym.o_valid, 0);
  endtask

  task automatic wait_valid();
    int cyc;
    cyc = 0;
    while (!sym.o_valid && cyc < 20) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    chk(sym.o_valid == 1'b1, "valid_timeout", sym.o_valid, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [NB_SCNT-1:0] c_before;
    i_reset = 1'b1; i_enable = 1'b0; i_inject = 1'b0; i_mode = 2'b00; sym.i_ready = 1'b0;
    #12;
    chk(sym.o_valid == 1'b0, "rst_valid", sym.o_valid, 0);
    chk(sym.o_data == '0, "rst_data", sym.o_data, 0);
    chk(o_state == 2'b00, "rst_state", o_state, 0);
    chk(o_sym_cnt == '0, "rst_cnt", o_sym_cnt, 0);
    i_reset = 1'b0;
    step(2);

    // PRBS7, always ready: latency, cadence, counter wrap, full period
    start_session(2'b00);
    sym.i_ready = 1'b1;
    wait_xfer(cyc);
    chk(cyc == 6, "first_latency", cyc, 6);
    for (int i = 1; i < 17; i++) begin
      wait_xfer(cyc);
      chk(cyc == 4, "xfer_interval", cyc, 4);
    end
    chk(o_sym_cnt == NB_SCNT'(1), "cnt_wrap_17", o_sym_cnt, 1);
    for (int i = 0; i < 130; i++) wait_xfer(cyc);

    // Error injection: pending flag (d=1,2) and coincident with production (d=3)
    for (int d = 1; d <= 3; d++) begin
      wait_xfer(cyc);
      exp_q[0] = exp_q[0] ^ N_CH'(1);
      step(d - 1);
      i_inject = 1'b1;
      step(1);
      i_inject = 1'b0;
      wait_xfer(cyc);
      wait_xfer(cyc);
    end

    // Mode change while running is ignored
    i_mode = 2'b10;
    for (int i = 0; i < 10; i++) wait_xfer(cyc);

    // Backpressure: hold ready low for 10 clocks once a symbol is up
    wait_xfer(cyc);
    sym.i_ready = 1'b0;
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk(o_state == 2'b10, "stall_state", o_state, 2);
      chk(sym.o_valid == 1'b1, "stall_valid", sym.o_valid, 1);
      chk(exp_q.size() != 0 && sym.o_data == exp_q[0], "stall_data", sym.o_data,
          (exp_q.size() != 0) ? exp_q[0] : 0);
      chk(o_sym_cnt == mdl_cnt, "stall_cnt", o_sym_cnt, mdl_cnt);
    end
    c_before = mdl_cnt;
    sym.i_ready = 1'b1;
    wait_xfer(cyc);
    chk(o_sym_cnt == c_before + 1'b1, "release_cnt", o_sym_cnt, c_before + 1'b1);

    // Restart picks up the new mode from seed
    stop_session();
    start_session(i_mode);
    sym.i_ready = 1'b1;
    for (int i = 0; i < 20; i++) wait_xfer(cyc);

    // Asynchronous reset between edges while stalled
    sym.i_ready = 1'b0;
    wait_valid();
    step(1);
    chk(o_state == 2'b10, "pre_reset_stall", o_state, 2);
    #1;
    i_reset = 1'b1;
    #1;
    chk(sym.o_valid == 1'b0, "async_rst_valid", sym.o_valid, 0);
    chk(sym.o_data == '0, "async_rst_data", sym.o_data, 0);
    chk(o_state == 2'b00, "async_rst_state", o_state, 0);
    chk(o_sym_cnt == '0, "async_rst_cnt", o_sym_cnt, 0);
    #1;
    i_reset   = 1'b0;
    mdl_cnt   = '0;
    exp_q.delete();
    sess_pops = 0;
    push_session(int'(i_mode));
    sym.i_ready = 1'b1;
    for (int i = 0; i < 10; i++) wait_xfer(cyc);

    // Random backpressure and mode wiggling, every pattern
    for (int s = 0; s < 5; s++) begin
      stop_session();
      start_session((s < 4) ? 2'(s) : 2'($urandom_range(0, 3)));
      step(1);
      for (int i = 0; i < 200; i++) begin
        sym.i_ready = ($urandom_range(0, 3) != 0);
        i_mode      = 2'($urandom_range(0, 3));
        step(1);
      end
    end
    stop_session();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
